cyc_wbuf: RTL and testbench
===========================

# cyc_wbuf

Parametrised cyclic weight buffer for the depthwise-conv PE array; successor to the single-channel 9-entry cyclic FIFO. Loads one kernel (DEPTH taps, NCH channels packed per word) over a valid/ready handshake, then replays it a programmable number of passes to the PE array under valid/ready backpressure. Replay emits pass/tap markers and a done pulse. Sits between the weight DMA and the dwpe input.

## Interface
- DW, 8, bits per channel weight
- NCH, 4, channels packed per word; word width W = NCH*DW
- DEPTH, 9, taps per kernel (≥2); AW = $clog2(DEPTH)
- CNTW, 16, width of replay-pass counter
- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous clear to EMPTY; highest priority after rst
- i_data  in  W  load word, channel c in bits [c*DW +: DW]
- i_valid  in  1  load word valid
- i_ready  out  1  buffer accepts load word
- start  in  1  begin replay (pulse; level ignored after acceptance)
- cfg_rep  in  CNTW  number of full passes, sampled on accepted start
- o_data  out  W  registered tap word
- o_valid  out  1  o_data valid
- o_ready  in  1  PE array accepts tap
- o_first  out  1  o_data is tap 0 of a pass
- o_last  out  1  o_data is tap DEPTH-1 of a pass
- o_done  out  1  one-cycle pulse after final tap transfers
- full  out  1  buffer holds a complete kernel, not replaying
- empty  out  1  buffer in EMPTY/LOAD state

## Operation
- States: EMPTY, LOAD, FULL, PLAY. i_ready = (state==EMPTY||LOAD); empty = same; full = (state==FULL).
- EMPTY: load fire (i_valid&&i_ready) writes mem[0], wptr←1, → LOAD.
- LOAD: each fire writes mem[wptr], wptr++. Fire at wptr==DEPTH-1 → FULL, wptr←0.
- FULL: start with cfg_rep≠0 → PLAY; rep_left←cfg_rep−1, rptr←1, o_data←mem[0], o_valid←1, o_first←1. start with cfg_rep==0 → EMPTY, o_done pulse, no output.
- PLAY: output fire = o_valid&&o_ready. On fire, o_data←mem[rptr]; rptr wraps DEPTH-1→0; o_first/o_last track tap index of new o_data. Fire of tap DEPTH-1 with rep_left==0 → o_valid←0, o_done←1, → EMPTY. Otherwise rep_left decrements on each fire of tap DEPTH-1.
- No fire: o_data, o_valid, markers hold (AXI-stable).
- start outside FULL ignored. i_valid while i_ready=0 ignored; data dropped, mem unchanged.
- flush: state→EMPTY, ptrs/counters→0, o_valid/o_first/o_last/o_done→0; mem contents not cleared. flush and start same cycle: flush wins.
- Memory is a register array, no reset; read index never reaches unwritten entries.

## Timing
- Reset (rst high): state EMPTY, i_ready=1, empty=1, full=0, o_valid=0, o_data=0, o_first=0, o_last=0, o_done=0; err=0 when compiled in.
- rst mid-replay: outputs to reset values immediately (async); replay lost.
- Load: DEPTH fires minimum, one per cycle; full asserts cycle after last fire.
- start latency: start sampled at edge t → o_valid=1 with tap 0 after edge t.
- Replay throughput: one tap/cycle with o_ready held high; DEPTH*cfg_rep cycles total, no bubbles between passes.
- o_done high for exactly the cycle after final fire; i_ready=1 that same cycle.
- Back-to-back: new load may start the cycle o_done is high.

## Configuration
- CYC_WBUF_ERR_EN defined: adds output err[1:0], sticky, cleared by rst or flush. err[0] set on start when state≠FULL. err[1] set on i_valid when i_ready=0.
- Undefined: err port absent; both conditions silently ignored, all other behaviour identical.

## Test plan
- Load taps 0..8 (channel c = tap*16+c), start cfg_rep=2, o_ready=1 -> 18 consecutive transfers taps 0..8,0..8; o_first on transfers 1,10; o_last on 9,18; o_done one cycle after 18th; empty=1.
- Same load, cfg_rep=1, o_ready toggling 1/0 -> o_data/o_valid stable during low cycles; exactly 9 transfers in order; o_done once.
- FULL, start with cfg_rep=0 -> no o_valid, o_done pulse next cycle, i_ready=1.
- Start during LOAD after 4 words, and i_valid held in FULL -> both ignored; replay after valid start still taps 0..8; with CYC_WBUF_ERR_EN err=2'b11.
- flush after 5th transfer of cfg_rep=3 -> o_valid=0 next cycle, empty=1, no o_done; reload new taps and replay returns new values.
- rst asserted mid-PLAY asynchronously -> o_valid=0, o_data=0 before next edge; next load/replay correct.

Source files
------------

// File: rtl/cyc_wbuf.sv
// cyc_wbuf: cyclic weight buffer for the depthwise-conv PE array.
//
// Loads one kernel of DEPTH tap words (NCH channels of DW bits packed per
// word) over a valid/ready handshake. It then replays the kernel cfg_rep
// times to the PE array, also under valid/ready backpressure.
//
// Optional feature: define CYC_WBUF_ERR_EN to add a sticky err[1:0] output.
//   err[0]: start seen while not FULL.
//   err[1]: i_valid seen while i_ready is low.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   flush              synchronous clear to EMPTY (memory contents kept)
//   i_data/i_valid/i_ready   kernel load handshake
//   start, cfg_rep     begin replay of cfg_rep passes (sampled in FULL)
//   o_data/o_valid/o_ready   registered tap stream to the PE array
//   o_first, o_last    o_data is tap 0 / tap DEPTH-1 of a pass
//   o_done             one-cycle pulse after the final tap transfers
//   full, empty        status (full: kernel held; empty: EMPTY/LOAD)
module cyc_wbuf #(
  parameter int unsigned DW    = 8,
  parameter int unsigned NCH   = 4,
  parameter int unsigned DEPTH = 9,
  parameter int unsigned CNTW  = 16,
  localparam int unsigned W    = NCH * DW,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic [W-1:0]    i_data,
  input  logic            i_valid,
  output logic            i_ready,
  input  logic            start,
  input  logic [CNTW-1:0] cfg_rep,
  output logic [W-1:0]    o_data,
  output logic            o_valid,
  input  logic            o_ready,
  output logic            o_first,
  output logic            o_last,
  output logic            o_done,
  output logic            full,
  output logic            empty
`ifdef CYC_WBUF_ERR_EN
  ,
  output logic [1:0]      err
`endif
);

  localparam logic [1:0] StEmpty = 2'd0;
  localparam logic [1:0] StLoad  = 2'd1;
  localparam logic [1:0] StFull  = 2'd2;
  localparam logic [1:0] StPlay  = 2'd3;

  localparam logic [AW-1:0] LastIdx = AW'(DEPTH - 1);

  logic [1:0]      state_q, state_d;
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [CNTW-1:0] rep_left_q, rep_left_d;
  logic [W-1:0]    o_data_q, o_data_d;
  logic            o_valid_q, o_valid_d;
  logic            o_first_q, o_first_d;
  logic            o_last_q, o_last_d;
  logic            o_done_q, o_done_d;

  logic [W-1:0]    mem [DEPTH];

  logic            load_fire;
  logic            out_fire;

  assign i_ready   = (state_q == StEmpty) || (state_q == StLoad);
  assign empty     = i_ready;
  assign full      = (state_q == StFull);
  assign load_fire = i_valid && i_ready && !flush;
  assign out_fire  = o_valid_q && o_ready;

  assign o_data  = o_data_q;
  assign o_valid = o_valid_q;
  assign o_first = o_first_q;
  assign o_last  = o_last_q;
  assign o_done  = o_done_q;

  // Kernel storage; intentionally not reset. Replay only reads indices that
  // a completed load has written.
  always_ff @(posedge clk) begin
    if (load_fire) begin
      mem[wptr_q] <= i_data;
    end
  end

  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    rep_left_d = rep_left_q;
    o_data_d   = o_data_q;
    o_valid_d  = o_valid_q;
    o_first_d  = o_first_q;
    o_last_d   = o_last_q;
    o_done_d   = 1'b0;

    if (flush) begin
      state_d    = StEmpty;
      wptr_d     = '0;
      rptr_d     = '0;
      rep_left_d = '0;
      o_valid_d  = 1'b0;
      o_first_d  = 1'b0;
      o_last_d   = 1'b0;
    end else begin
      case (state_q)
        StEmpty: begin
          if (i_valid) begin
            wptr_d  = AW'(1);
            state_d = StLoad;
          end
        end
        StLoad: begin
          if (i_valid) begin
            if (wptr_q == LastIdx) begin
              wptr_d  = '0;
              state_d = StFull;
            end else begin
              wptr_d = wptr_q + AW'(1);
            end
          end
        end
        StFull: begin
          if (start) begin
            if (cfg_rep != '0) begin
              state_d    = StPlay;
              rep_left_d = cfg_rep - CNTW'(1);
              rptr_d     = AW'(1);
              o_data_d   = mem[0];
              o_valid_d  = 1'b1;
              o_first_d  = 1'b1;
              o_last_d   = 1'b0;
            end else begin
              // Zero passes requested: complete immediately, emit nothing.
              state_d  = StEmpty;
              o_done_d = 1'b1;
            end
          end
        end
        StPlay: begin
          if (out_fire) begin
            if (o_last_q && (rep_left_q == '0)) begin
              state_d   = StEmpty;
              rptr_d    = '0;
              o_valid_d = 1'b0;
              o_first_d = 1'b0;
              o_last_d  = 1'b0;
              o_done_d  = 1'b1;
            end else begin
              // rptr always names the tap that follows the one on o_data.
              o_data_d  = mem[rptr_q];
              o_first_d = (rptr_q == '0);
              o_last_d  = (rptr_q == LastIdx);
              rptr_d    = (rptr_q == LastIdx) ? '0 : rptr_q + AW'(1);
              if (o_last_q) begin
                rep_left_d = rep_left_q - CNTW'(1);
              end
            end
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StEmpty;
      wptr_q     <= '0;
      rptr_q     <= '0;
      rep_left_q <= '0;
      o_data_q   <= '0;
      o_valid_q  <= 1'b0;
      o_first_q  <= 1'b0;
      o_last_q   <= 1'b0;
      o_done_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      rep_left_q <= rep_left_d;
      o_data_q   <= o_data_d;
      o_valid_q  <= o_valid_d;
      o_first_q  <= o_first_d;
      o_last_q   <= o_last_d;
      o_done_q   <= o_done_d;
    end
  end

`ifdef CYC_WBUF_ERR_EN
  logic [1:0] err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (flush) begin
      err_d = '0;
    end else begin
      if (start && (state_q != StFull)) err_d[0] = 1'b1;
      if (i_valid && !i_ready)          err_d[1] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= '0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_cyc_wbuf.sv
// Self-checking bench for cyc_wbuf (default build, error port absent).
module tb_cyc_wbuf;

  localparam int DW    = 8;
  localparam int NCH   = 4;
  localparam int DEPTH = 9;
  localparam int CNTW  = 16;
  localparam int W     = NCH * DW;
  localparam int NVEC  = 29;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic [W-1:0]    i_data;
  logic            i_valid;
  logic            i_ready;
  logic            start;
  logic [CNTW-1:0] cfg_rep;
  logic [W-1:0]    o_data;
  logic            o_valid;
  logic            o_ready;
  logic            o_first;
  logic            o_last;
  logic            o_done;
  logic            full;
  logic            empty;

  int tests = 0;
  int fails = 0;

  cyc_wbuf #(
    .DW   (DW),
    .NCH  (NCH),
    .DEPTH(DEPTH),
    .CNTW (CNTW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .i_data (i_data),
    .i_valid(i_valid),
    .i_ready(i_ready),
    .start  (start),
    .cfg_rep(cfg_rep),
    .o_data (o_data),
    .o_valid(o_valid),
    .o_ready(o_ready),
    .o_first(o_first),
    .o_last (o_last),
    .o_done (o_done),
    .full   (full),
    .empty  (empty)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic            iv;
    logic [W-1:0]    id;
    logic            st;
    logic [CNTW-1:0] rep;
    logic            ordy;
    logic            ev;
    logic [W-1:0]    edata;
    logic            efirst;
    logic            elast;
    logic            edone;
    logic            eirdy;
    logic            efull;
    logic            eempty;
  } vec_t;

  vec_t tbl [NVEC];

  // Channel c of tap t = base ^ (t*16 + c).
  function automatic logic [W-1:0] word(input int t, input logic [7:0] base);
    logic [W-1:0] w;
    for (int c = 0; c < NCH; c++) begin
      w[c*DW +: DW] = base ^ 8'(t * 16 + c);
    end
    return w;
  endfunction

  function automatic vec_t mk(input logic iv, input logic [W-1:0] id, input logic st,
                              input logic [CNTW-1:0] rep, input logic ordy, input logic ev,
                              input logic [W-1:0] edata, input logic efirst,
                              input logic elast, input logic edone, input logic eirdy,
                              input logic efull, input logic eempty);
    vec_t v;
    v.iv = iv; v.id = id; v.st = st; v.rep = rep; v.ordy = ordy;
    v.ev = ev; v.edata = edata; v.efirst = efirst; v.elast = elast;
    v.edone = edone; v.eirdy = eirdy; v.efull = efull; v.eempty = eempty;
    return v;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_kernel(input logic [7:0] base);
    for (int t = 0; t < DEPTH; t++) begin
      i_valid = 1'b1;
      i_data  = word(t, base);
      tick;
    end
    i_valid = 1'b0;
    chk("load_full", full, 1);
    chk("load_iready", i_ready, 0);
  endtask

  // Starts a replay from FULL and checks every tap, marker and the done pulse.
  task automatic run_replay(input int rep, input logic [7:0] base, input bit toggle);
    int n;
    int cyc;
    int total;
    int tap;
    total   = rep * DEPTH;
    n       = 0;
    cyc     = 0;
    start   = 1'b1;
    cfg_rep = CNTW'(rep);
    o_ready = 1'b0;
    tick;
    start = 1'b0;
    while (n < total && cyc < 400) begin
      o_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      tap = n % DEPTH;
      chk("rp_valid", o_valid, 1);
      if (!o_valid) break;
      chk("rp_data", o_data, word(tap, base));
      chk("rp_first", o_first, tap == 0);
      chk("rp_last", o_last, tap == DEPTH - 1);
      chk("rp_done_early", o_done, 0);
      if (o_ready) n++;
      tick;
      cyc++;
    end
    chk("rp_count", n, total);
    if (!toggle) chk("rp_cycles", cyc, total);
    chk("rp_done_pulse", o_done, 1);
    chk("rp_valid_end", o_valid, 0);
    chk("rp_iready_end", i_ready, 1);
    chk("rp_empty_end", empty, 1);
    o_ready = 1'b0;
    tick;
    chk("rp_done_once", o_done, 0);
  endtask

  initial begin
    // Test 1 vectors: load taps 0..8, replay twice with o_ready high.
    for (int k = 0; k < DEPTH; k++) begin
      tbl[k] = mk(1'b1, word(k, 8'h00), 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0,
                  k < DEPTH - 1, k == DEPTH - 1, k < DEPTH - 1);
    end
    tbl[9] = mk(1'b0, '0, 1'b1, 16'd2, 1'b1, 1'b1, word(0, 8'h00), 1'b1, 1'b0, 1'b0,
                1'b0, 1'b0, 1'b0);
    for (int j = 1; j < 18; j++) begin
      tbl[9 + j] = mk(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, word(j % 9, 8'h00), (j % 9) == 0,
                      (j % 9) == 8, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    tbl[27] = mk(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    tbl[28] = mk(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

    rst     = 1'b1;
    flush   = 1'b0;
    i_valid = 1'b0;
    i_data  = '0;
    start   = 1'b0;
    cfg_rep = '0;
    o_ready = 1'b0;
    tick;
    chk("rst_valid", o_valid, 0);
    chk("rst_data", o_data, 0);
    chk("rst_first", o_first, 0);
    chk("rst_last", o_last, 0);
    chk("rst_done", o_done, 0);
    chk("rst_iready", i_ready, 1);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    rst = 1'b0;
    tick;

    // Test 1: table-driven.
    for (int k = 0; k < NVEC; k++) begin
      i_valid = tbl[k].iv;
      i_data  = tbl[k].id;
      start   = tbl[k].st;
      cfg_rep = tbl[k].rep;
      o_ready = tbl[k].ordy;
      tick;
      chk("t1_valid", o_valid, tbl[k].ev);
      if (tbl[k].ev) chk("t1_data", o_data, tbl[k].edata);
      chk("t1_first", o_first, tbl[k].efirst);
      chk("t1_last", o_last, tbl[k].elast);
      chk("t1_done", o_done, tbl[k].edone);
      chk("t1_iready", i_ready, tbl[k].eirdy);
      chk("t1_full", full, tbl[k].efull);
      chk("t1_empty", empty, tbl[k].eempty);
    end
    i_valid = 1'b0;
    start   = 1'b0;
    o_ready = 1'b0;

    // Test 2: one pass with o_ready toggling.
    load_kernel(8'h00);
    run_replay(1, 8'h00, 1'b1);

    // Test 3: zero passes.
    load_kernel(8'h00);
    start   = 1'b1;
    cfg_rep = '0;
    tick;
    start = 1'b0;
    chk("z_valid", o_valid, 0);
    chk("z_done", o_done, 1);
    chk("z_iready", i_ready, 1);
    chk("z_empty", empty, 1);
    tick;
    chk("z_done_once", o_done, 0);
    chk("z_valid2", o_valid, 0);

    // Test 4: start during LOAD and i_valid in FULL are ignored.
    for (int t = 0; t < 4; t++) begin
      i_valid = 1'b1;
      i_data  = word(t, 8'h00);
      tick;
    end
    i_valid = 1'b0;
    start   = 1'b1;
    cfg_rep = 16'd2;
    tick;
    start = 1'b0;
    chk("ign_start_valid", o_valid, 0);
    chk("ign_start_empty", empty, 1);
    chk("ign_start_full", full, 0);
    for (int t = 4; t < DEPTH; t++) begin
      i_valid = 1'b1;
      i_data  = word(t, 8'h00);
      tick;
    end
    chk("ign_full", full, 1);
    for (int t = 0; t < 2; t++) begin
      i_valid = 1'b1;
      i_data  = word(t, 8'hFF);
      tick;
    end
    i_valid = 1'b0;
    chk("ign_ival_full", full, 1);
    chk("ign_ival_valid", o_valid, 0);
    run_replay(1, 8'h00, 1'b0);

    // Test 5: flush after the 5th transfer of a 3-pass replay.
    load_kernel(8'h00);
    o_ready = 1'b1;
    start   = 1'b1;
    cfg_rep = 16'd3;
    tick;
    start = 1'b0;
    repeat (5) tick;
    chk("fl_pre_data", o_data, word(5, 8'h00));
    flush = 1'b1;
    tick;
    flush = 1'b0;
    chk("fl_valid", o_valid, 0);
    chk("fl_empty", empty, 1);
    chk("fl_done", o_done, 0);
    chk("fl_first", o_first, 0);
    tick;
    chk("fl_done2", o_done, 0);
    o_ready = 1'b0;
    load_kernel(8'h5A);
    run_replay(1, 8'h5A, 1'b0);

    // Test 6: asynchronous reset mid-replay.
    load_kernel(8'h00);
    o_ready = 1'b1;
    start   = 1'b1;
    cfg_rep = 16'd2;
    tick;
    start = 1'b0;
    tick;
    tick;
    #2;
    rst = 1'b1;
    #1;
    chk("ar_valid", o_valid, 0);
    chk("ar_data", o_data, 0);
    chk("ar_empty", empty, 1);
    chk("ar_first", o_first, 0);
    rst     = 1'b0;
    o_ready = 1'b0;
    tick;
    load_kernel(8'h3C);
    run_replay(2, 8'h3C, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
